// File: rtl/rv32_pipe_pkg.sv
// rtl/rv32_pipe_pkg.sv - shared RV32 pipeline constants and the IF->ID fetch entry type
package rv32_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/sync_flush_fifo.sv
// rtl/sync_flush_fifo.sv - register-based FIFO with a synchronous flush that clears pointers and count
module sync_flush_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           wr_en_i,
  input  entry_t                         wr_data_i,
  input  logic                           rd_en_i,
  output entry_t                         rd_data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_flush_fifo: DEPTH must be a power of 2 and >= 2");
  end

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_rd = rd_en_i & ~empty_o;
  assign do_wr = wr_en_i & (~full_o | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/rv32_fetch_queue.sv
// rtl/rv32_fetch_queue.sv - decoupled IF stage: PC generator and fetch buffer; FETCH_PERF_CNT_EN adds perf counters
module rv32_fetch_queue #(
  parameter int              XLEN     = rv32_pipe_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 7,
  parameter logic [XLEN-1:0] RESET_PC = rv32_pipe_pkg::RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [31:0]                id_inst,
  output logic [XLEN-1:0]            id_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                perf_empty_cyc,
  output logic [31:0]                perf_redirects
);
  import rv32_pipe_pkg::*;

  if (XLEN != $bits(fetch_entry_t) - 32) begin : g_bad_xlen
    $error("rv32_fetch_queue: XLEN must match rv32_pipe_pkg::XLEN");
  end

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  fetch_entry_t    wr_entry, head;
  logic            full, empty, enq, deq;
  logic            unused_bits;

  assign deq       = ~empty & id_ready;
  assign enq       = ~redirect_valid & (~full | deq);
  assign imem_addr = fetch_pc_q[IMEM_AW+1:2];
  assign wr_entry  = '{pc: fetch_pc_q, inst: imem_data};

  assign unused_bits = ^{redirect_pc[1:0], fetch_pc_q[XLEN-1:IMEM_AW+2]};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (enq)        fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  // Redirect flushes the buffer; the flush outranks any same-cycle write or read.
  sync_flush_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (redirect_valid),
    .wr_en_i   (enq),
    .wr_data_i (wr_entry),
    .rd_en_i   (deq),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (occupancy)
  );

  assign id_valid = ~empty;
  assign id_inst  = empty ? NOP_INST : head.inst;
  assign id_pc    = empty ? '0 : head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_empty_q, perf_redir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_empty_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (!id_valid)      perf_empty_q <= perf_empty_q + 32'd1;
      if (redirect_valid) perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_empty_cyc = perf_empty_q;
  assign perf_redirects = perf_redir_q;
`else
  assign perf_empty_cyc = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// tb/tb_rv32_fetch_queue.sv - scoreboard bench for rv32_fetch_queue against a queue-based fetch model
module tb_rv32_fetch_queue;
  import rv32_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [2:0]  occupancy;
  logic [31:0] perf_empty_cyc;
  logic [31:0] perf_redirects;

  logic [31:0] rom [128];

  always #5 clk = ~clk;
  assign imem_data = rom[imem_addr];

  rv32_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .occupancy      (occupancy),
    .perf_empty_cyc (perf_empty_cyc),
    .perf_redirects (perf_redirects)
  );

  typedef struct {
    logic [2:0]  occ;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  iaddr;
    logic [31:0] pe;
    logic [31:0] pr;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] deq_q[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_fpc, m_pe, m_pr;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, records what the DUT should show this cycle, then advances the model.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    exp_t e;
    int   sz;
    logic deq;
    @(posedge clk);
    #1;
    rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    sz      = m_buf.size();
    e.occ   = 3'(sz);
    e.valid = (sz > 0);
    e.pc    = (sz > 0) ? m_buf[0] : 32'h0;
    e.inst  = (sz > 0) ? rom[m_buf[0][8:2]] : NOP_INST;
    e.iaddr = m_fpc[8:2];
`ifdef FETCH_PERF_CNT_EN
    e.pe = m_pe;
    e.pr = m_pr;
`else
    e.pe = 32'h0;
    e.pr = 32'h0;
`endif
    cyc_q.push_back(e);
    if (r) begin
      m_buf.delete();
      m_fpc = 32'h0; m_pe = 32'h0; m_pr = 32'h0;
    end else begin
      if (sz == 0) m_pe++;
      if (rv) begin
        m_pr++;
        m_buf.delete();
        m_fpc = rpc & ~32'h3;
      end else begin
        deq = (sz > 0) && rdy;
        if (deq) deq_q.push_back(m_buf.pop_front());
        if (sz < 4 || deq) begin
          m_buf.push_back(m_fpc);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] p;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("occupancy", 32'(occupancy), 32'(e.occ));
      chk("id_valid", 32'(id_valid), 32'(e.valid));
      chk("id_pc", id_pc, e.pc);
      chk("id_inst", id_inst, e.inst);
      chk("imem_addr", 32'(imem_addr), 32'(e.iaddr));
      chk("perf_empty_cyc", perf_empty_cyc, e.pe);
      chk("perf_redirects", perf_redirects, e.pr);
      if (id_valid && id_ready && !redirect_valid && !rst) begin
        if (deq_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq: unexpected handshake id_pc=%h expected none", id_pc);
        end else begin
          p = deq_q.pop_front();
          chk("deq_pc", id_pc, p);
          chk("deq_inst", id_inst, rom[p[8:2]]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    m_buf.delete();
    m_fpc = 32'h0; m_pe = 32'h0; m_pr = 32'h0;
    repeat (2) @(posedge clk);

    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 32'h40, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h43, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0, $urandom,
            $urandom_range(0, 3) != 0);

    @(negedge clk);
    #1;
    chk("deq_leftover", 32'(deq_q.size()), 32'h0);
    chk("cycle_leftover", 32'(cyc_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
